// File: rtl/rv_pkg.sv
// Shared RV32I decode constants, immediate classes, FSM encoding and the
// decode-stage output bundle.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_READ, ST_VALID
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        illegal;
  } dec_t;

  // IMM_NONE doubles as the "illegal encoding" class.
  function automatic imm_type_e imm_type_of(input logic [31:0] instr);
    imm_type_e t;
    t = IMM_NONE;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: t = IMM_I;
        OP_STORE:                            t = IMM_S;
        OP_BRANCH:                           t = IMM_B;
        OP_LUI, OP_AUIPC:                    t = IMM_U;
        OP_JAL:                              t = IMM_J;
        OP_REG:                              t = IMM_R;
        default:                             t = IMM_NONE;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extractor: sign-extended immediate by instruction
// format, zero with illegal flagged for unknown encodings.
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output logic        illegal
);

  imm_type_e t;

  always_comb begin
    t       = imm_type_of(instr);
    imm     = '0;
    illegal = 1'b0;
    case (t)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_R: imm = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: reads the register file, retries reads that collide with a
// concurrent write-back, and presents a decoded instruction to execute.
module id_stage
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  output logic        rf_re,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic        out_illegal
);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        coll_q, coll_d;
  dec_t        out_q, out_d;

  logic [31:0] imm;
  logic        illegal;
  imm_type_e   itype;

  imm_gen u_imm_gen (
    .instr   (instr_q),
    .imm     (imm),
    .illegal (illegal)
  );

  assign itype = imm_type_of(instr_q);

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    out_d    = out_q;
    in_ready = (state_q == ST_IDLE) && !flush;
    rf_re    = 1'b0;
    rf_ra1   = instr_q[19:15];
    rf_ra2   = instr_q[24:20];

    case (state_q)
      ST_IDLE: begin
        rf_ra1 = in_instr[19:15];
        rf_ra2 = in_instr[24:20];
        if (in_valid && in_ready) begin
          instr_d = in_instr;
          pc_d    = in_pc;
          rf_re   = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (coll_q) begin
          rf_re = 1'b1;
        end else begin
          out_d.pc       = pc_q;
          out_d.rs1_val  = (instr_q[19:15] == 5'd0) ? 32'd0 : rf_rd1;
          out_d.rs2_val  = (instr_q[24:20] == 5'd0) ? 32'd0 : rf_rd2;
          out_d.imm      = imm;
          out_d.rd       = (itype == IMM_S || itype == IMM_B) ? 5'd0 : instr_q[11:7];
          out_d.opcode   = instr_q[6:0];
          out_d.funct3   = instr_q[14:12];
          out_d.funct7b5 = instr_q[30];
          out_d.illegal  = illegal;
          state_d        = ST_VALID;
        end
      end
      ST_VALID: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush drops whatever is in flight, including a pending re-read.
    if (flush || rst) begin
      state_d = ST_IDLE;
      rf_re   = 1'b0;
    end

    // Write to x0 still counts as a hit; the retry is cheap and keeps it simple.
    coll_d = rf_re && wb_we && ((wb_wa == rf_ra1) || (wb_wa == rf_ra2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      coll_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      coll_q  <= coll_d;
      out_q   <= out_d;
    end
  end

  assign out_valid    = (state_q == ST_VALID);
  assign out_pc       = out_q.pc;
  assign out_rs1_val  = out_q.rs1_val;
  assign out_rs2_val  = out_q.rs2_val;
  assign out_imm      = out_q.imm;
  assign out_rd       = out_q.rd;
  assign out_opcode   = out_q.opcode;
  assign out_funct3   = out_q.funct3;
  assign out_funct7b5 = out_q.funct7b5;
  assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios then randomized instructions, checked
// against a behavioural decode model and a simple registered regfile.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_ra1, rf_ra2;
  logic        rf_re;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_re(rf_re), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_wa(wb_wa), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_rd(out_rd), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
  );

  // Register file: data appears one cycle after a read; garbage otherwise.
  always @(posedge clk) begin
    if (rf_re) begin
      rf_rd1 <= rf[rf_ra1];
      rf_rd2 <= rf[rf_ra2];
    end else begin
      rf_rd1 <= $urandom;
      rf_rd2 <= $urandom;
    end
  end

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5, ill;
  } exp_t;

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [31:0] sx;
    sx      = 32'($signed(i) >>> 20);
    e.pc    = pc;
    e.rs1   = (i[19:15] == 0) ? 32'd0 : rf[i[19:15]];
    e.rs2   = (i[24:20] == 0) ? 32'd0 : rf[i[24:20]];
    e.opc   = i[6:0];
    e.f3    = i[14:12];
    e.f7b5  = i[30];
    e.rd    = i[11:7];
    e.ill   = 1'b0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: e.imm = sx;
      7'h23: begin e.imm = (sx & ~32'h1F) | {27'd0, i[11:7]}; e.rd = 0; end
      7'h63: begin e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; e.rd = 0; end
      7'h37, 7'h17: e.imm = i & 32'hFFFF_F000;
      7'h6F: e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      7'h33: e.imm = 32'd0;
      default: begin e.imm = 32'd0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, " pc"},   out_pc, e.pc);
    chk({tag, " rs1"},  out_rs1_val, e.rs1);
    chk({tag, " rs2"},  out_rs2_val, e.rs2);
    chk({tag, " imm"},  out_imm, e.imm);
    chk({tag, " rd"},   {27'd0, out_rd}, {27'd0, e.rd});
    chk({tag, " opc"},  {25'd0, out_opcode}, {25'd0, e.opc});
    chk({tag, " f3"},   {29'd0, out_funct3}, {29'd0, e.f3});
    chk({tag, " f7b5"}, {31'd0, out_funct7b5}, {31'd0, e.f7b5});
    chk({tag, " ill"},  {31'd0, out_illegal}, {31'd0, e.ill});
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [4:0] other_idx(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] w;
    w = 5'($urandom_range(0, 31));
    while (w == a || w == b) w = w + 5'd1;
    return w;
  endfunction

  // One full transaction: ncoll forced retries, hold cycles of backpressure,
  // then either accept at execute or flush out of VALID.
  task automatic send(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                      input int ncoll, input int hold, input bit end_flush);
    exp_t e;
    logic [4:0] rs1, rs2;
    rs1 = instr[19:15];
    rs2 = instr[24:20];
    in_valid = 1; in_instr = instr; in_pc = pc;
    wb_we = (ncoll > 0) ? 1'b1 : 1'($urandom_range(0, 1));
    wb_wa = (ncoll > 0) ? rs1 : other_idx(rs1, rs2);
    @(negedge clk);
    chk({tag, " accept in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, " accept rf_re"}, {31'd0, rf_re}, 32'd1);
    chk({tag, " ra1"}, {27'd0, rf_ra1}, {27'd0, rs1});
    chk({tag, " ra2"}, {27'd0, rf_ra2}, {27'd0, rs2});
    next_cyc();
    in_valid = 0; in_instr = $urandom; in_pc = $urandom;
    for (int c = 1; c <= ncoll; c++) begin
      wb_we = (c < ncoll);
      wb_wa = rs2;
      @(negedge clk);
      chk({tag, " retry rf_re"}, {31'd0, rf_re}, 32'd1);
      chk({tag, " retry ra1"}, {27'd0, rf_ra1}, {27'd0, rs1});
      chk({tag, " retry ra2"}, {27'd0, rf_ra2}, {27'd0, rs2});
      chk({tag, " retry out_valid"}, {31'd0, out_valid}, 32'd0);
      next_cyc();
    end
    wb_we = 1'($urandom_range(0, 1));
    wb_wa = other_idx(rs1, rs2);
    @(negedge clk);
    chk({tag, " read rf_re"}, {31'd0, rf_re}, 32'd0);
    chk({tag, " read out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " read in_ready"}, {31'd0, in_ready}, 32'd0);
    next_cyc();
    wb_we = 0;
    e = model(instr, pc);
    out_ready = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
      chk_out({tag, " hold"}, e);
      next_cyc();
    end
    if (end_flush) begin
      flush = 1; out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk({tag, " flushcyc out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, " flushcyc in_ready"}, {31'd0, in_ready}, 32'd0);
      next_cyc();
      flush = 0; out_ready = 0;
    end else begin
      out_ready = 1;
      @(negedge clk);
      chk({tag, " valid"}, {31'd0, out_valid}, 32'd1);
      chk_out(tag, e);
      next_cyc();
      out_ready = 0;
    end
    @(negedge clk);
    chk({tag, " after out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " after in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, " after rf_re"}, {31'd0, rf_re}, 32'd0);
    next_cyc();
  endtask

  logic [6:0] opcs [12];

  initial begin
    opcs = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33,
             7'h00, 7'h5B};
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    rf[0] = 32'hDEAD_BEEF;
    rf[1] = 32'd2;
    rf[2] = 32'd3;
    rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; wb_we = 0; wb_wa = 0;
    flush = 0; out_ready = 0;
    next_cyc(); next_cyc();
    rst = 0;
    @(negedge clk);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset rf_re", {31'd0, rf_re}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_pc", out_pc, 32'd0);
    chk("reset out_imm", out_imm, 32'd0);
    chk("reset out_rs1", out_rs1_val, 32'd0);
    next_cyc();

    send("add", 32'h002081B3, 32'h0000_1000, 0, 0, 0);
    send("add_coll", 32'h002081B3, 32'h0000_1004, 1, 0, 0);
    send("addi_neg", 32'hFFF00293, 32'h0000_1008, 0, 0, 0);
    send("sw", 32'h00112623, 32'h0000_100C, 0, 1, 0);
    send("zero_illegal", 32'h0000_0000, 32'h0000_1010, 0, 0, 0);
    send("hold_flush", 32'h002081B3, 32'h0000_1014, 0, 5, 1);

    // Flush beats an offered instruction in IDLE.
    in_valid = 1; in_instr = 32'h002081B3; flush = 1;
    @(negedge clk);
    chk("flushacc in_ready", {31'd0, in_ready}, 32'd0);
    chk("flushacc rf_re", {31'd0, rf_re}, 32'd0);
    next_cyc();
    in_valid = 0; flush = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flushacc out_valid", {31'd0, out_valid}, 32'd0);
      chk("flushacc rf_re2", {31'd0, rf_re}, 32'd0);
      next_cyc();
    end

    // Flush during a colliding READ.
    in_valid = 1; in_instr = 32'h002081B3; wb_we = 1; wb_wa = 5'd2;
    next_cyc();
    in_valid = 0; wb_we = 1; wb_wa = 5'd1; flush = 1;
    next_cyc();
    flush = 0; wb_we = 0;
    @(negedge clk);
    chk("flushrd rf_re", {31'd0, rf_re}, 32'd0);
    chk("flushrd out_valid", {31'd0, out_valid}, 32'd0);
    chk("flushrd in_ready", {31'd0, in_ready}, 32'd1);
    next_cyc();

    // Reset in a colliding READ; reset also beats a flush.
    in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'hABCD_0000; wb_we = 1; wb_wa = 5'd1;
    next_cyc();
    in_valid = 0; rst = 1; flush = 1;
    next_cyc();
    rst = 0; flush = 0; wb_we = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rstrd rf_re", {31'd0, rf_re}, 32'd0);
      chk("rstrd out_valid", {31'd0, out_valid}, 32'd0);
      chk("rstrd out_pc", out_pc, 32'd0);
      next_cyc();
    end

    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    for (int t = 0; t < 60; t++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) ins[1:0] = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) ins[19:15] = 5'd0;
      if ($urandom_range(0, 5) == 0) ins[24:20] = 5'd0;
      send("rand", ins, $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
           $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
